// File: rtl/multiply_control.sv
// multiply_control: Moore sequencer for a 4x4 shift-add DataUnit.
// Latches the operands on an accepted Start, steps the DataUnit through
// LOAD, four SHIFT and three ADD cycles, FINAL and DONE, then captures the product.
module multiply_control (
  input  logic       clock,
  input  logic       reset,
  input  logic       Start,
  input  logic [3:0] MultiplicantIn,
  input  logic [3:0] MultiplierIn,
  input  logic [7:0] Product,
  output logic [3:0] Multiplicant,
  output logic [3:0] Multiplier,
  output logic [2:0] Shift1,
  output logic [2:0] Shift0,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Result,
  output logic       ResultValid
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    ADD   = 3'd3,
    FINAL = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state, state_n;
  logic [1:0] cnt;

  // Control code for a state: {Shift1, Shift0}.
  function automatic logic [5:0] codes(input state_t s);
    case (s)
      LOAD:    codes = {3'b101, 3'b101};
      SHIFT:   codes = {3'b010, 3'b010};
      ADD:     codes = {3'b111, 3'b000};
      FINAL:   codes = {3'b011, 3'b000};
      default: codes = {3'b000, 3'b000};
    endcase
  endfunction

  // Next-state logic; DONE and any unused encoding fall back to IDLE.
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = Start ? LOAD : IDLE;
      LOAD:    state_n = SHIFT;
      SHIFT:   state_n = (cnt == 2'd3) ? FINAL : ADD;
      ADD:     state_n = SHIFT;
      FINAL:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // State, counter, operand/result registers and Moore outputs registered
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      Multiplicant <= 4'd0;
      Multiplier   <= 4'd0;
      Shift1       <= 3'b000;
      Shift0       <= 3'b000;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Result       <= 8'h00;
      ResultValid  <= 1'b0;
    end else begin
      state            <= state_n;
      {Shift1, Shift0} <= codes(state_n);
      Busy             <= (state_n != IDLE);
      Done             <= (state_n == DONE);
      // Start is only looked at in IDLE; accepting it latches operands,
      // clears the iteration count and retires the previous result.
      if (state == IDLE && Start) begin
        Multiplicant <= MultiplicantIn;
        Multiplier   <= MultiplierIn;
        cnt          <= 2'd0;
        ResultValid  <= 1'b0;
      end
      if (state == ADD)
        cnt <= cnt + 2'd1;
      // Product is taken verbatim from the DataUnit on the way out of DONE.
      if (state == DONE) begin
        Result      <= Product;
        ResultValid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/multiply_control.md
MULTIPLY_CONTROL -- requirements
Module: multiply_control

Interface
REQ-001 Clock and reset shall be: one clock; reset is asynchronous and active-low; ports named clock and reset.
REQ-002 The ports shall be as follows (name, direction, width, meaning):
- clock  input  1  rising-edge clock.
- reset  input  1  async active-low reset.
- Start  input  1  request a multiply; sampled only in IDLE.
- MultiplicantIn  input  4  operand A from requester.
- MultiplierIn  input  4  operand B from requester.
- Product  input  8  product bus returned by DataUnit.
- Multiplicant  output  4  latched operand A to DataUnit.
- Multiplier  output  4  latched operand B to DataUnit.
- Shift1  output  3  upper-register control code to DataUnit.
- Shift0  output  3  lower-register control code to DataUnit.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse in DONE.
- Result  output  8  captured product.
- ResultValid  output  1  Result holds a completed product.

Function
REQ-003 The block shall be a Moore FSM with states IDLE, LOAD, SHIFT, ADD, FINAL, DONE; Shift1/Shift0 shall be decoded from the state only.
REQ-004 Codes (Shift1/Shift0) shall be: IDLE 000/000; LOAD 101/101; SHIFT 010/010; ADD 111/000; FINAL 011/000; DONE 000/000.
REQ-005 In IDLE with Start=1 at a rising edge, the block shall enter LOAD and latch MultiplicantIn/MultiplierIn into Multiplicant/Multiplier at that same edge.
REQ-006 In IDLE with Start=0, the block shall stay in IDLE.
REQ-007 Start in any non-IDLE state shall be ignored; no latch and no restart.
REQ-008 LOAD shall go to SHIFT after exactly one cycle.
REQ-009 A 2-bit iteration counter shall clear on entry to LOAD and increment on each exit from ADD.
REQ-010 SHIFT shall go to ADD when the counter is below 3, and to FINAL when the counter equals 3.
REQ-011 ADD shall always go to SHIFT.
REQ-012 The state order shall be LOAD, SHIFT, ADD, SHIFT, ADD, SHIFT, ADD, SHIFT, FINAL, DONE, i.e. 4 SHIFT and 3 ADD cycles.
REQ-013 FINAL shall go to DONE, and DONE shall go to IDLE unconditionally.
REQ-014 Start high during DONE shall not be accepted; it is accepted only if it is still high in the following IDLE cycle.
REQ-015 Latency: with Start accepted at edge 0, LOAD shall occupy cycle 1, FINAL cycle 9 and DONE cycle 10; Result shall be valid after edge 11.
REQ-016 Done shall be 1 only in DONE.
REQ-017 At the edge leaving DONE, Result shall load Product and ResultValid shall set to 1.
REQ-018 ResultValid shall clear at the edge where a new Start is accepted.
REQ-019 Result shall hold its value until the next capture.
REQ-020 Multiplicant/Multiplier shall be stable from LOAD through DONE regardless of changes on MultiplicantIn/MultiplierIn.
REQ-021 Busy shall be the complement of (state==IDLE).
REQ-022 Result shall be zero-extended 8-bit as produced by DataUnit; the block performs no arithmetic on Product.
REQ-023 Unused state encodings shall return to IDLE on the next edge.

Reset
REQ-024 reset=0 shall immediately force: state IDLE; counter 0; Multiplicant=0, Multiplier=0; Shift1/Shift0=000/000; Busy=0, Done=0; Result=0x00, ResultValid=0.
REQ-025 Reset mid-operation shall abort the sequence without capturing Result.
REQ-026 On reset release, the block shall wait in IDLE for Start.
REQ-027 Start high at the first edge after reset release shall be accepted as a normal request.

Verification
REQ-028 A=3, B=7, 1-cycle Start pulse (DataUnit in loop) -> code sequence 101/101, 010/010, 111/000 x3 interleaved, 010/010, 011/000; Done pulse in cycle 10; Result=0x15, ResultValid=1 after edge 11.
REQ-029 A=12, B=12 -> Result=0x90; A=0, B=15 -> Result=0x00; A=5, B=5 -> Result=0x19.
REQ-030 Start held high continuously, A=12, B=6 -> exactly one operation per 11-cycle window (10 busy + 1 IDLE); each Result=0x48; Start pulses during Busy cause no restart.
REQ-031 MultiplicantIn/MultiplierIn changed to 15/15 in cycle 4 of a 3x7 run -> latched operands stay 3/7; Result=0x15.
REQ-032 reset=0 asserted mid-cycle during ADD -> all outputs reach their reset values before the next edge; ResultValid stays 0.
REQ-033 After REQ-032, a new 5x5 request -> Result=0x19.
